instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the main control decoder in the single-cycle-derived MIPS datapath.
- Holds the PC and issues one request at a time to a variable-latency instruction memory.
- Presents the fetched word and its opcode field to the decoder with a valid/ready handshake.
- Redirects the PC on a taken beq/bne reported by the downstream stage when that branch instruction is consumed.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 32: width of the consumed-instruction counter.

Ports:
- clk_i, input, 1: clock, rising-edge.
- rst_i, input, 1: reset, asynchronous, active-high.
- imem_req_o, output, 1: fetch request to instruction memory.
- imem_addr_o, output, 32: fetch address (byte address, word aligned).
- imem_ack_i, input, 1: memory returns data this cycle.
- imem_rdata_i, input, 32: instruction word, valid when imem_ack_i=1.
- instr_valid_o, output, 1: instr_o/opcode_o/pc_plus4_o are valid.
- instr_ready_i, input, 1: downstream consumes the instruction this cycle.
- instr_o, output, 32: held instruction word.
- opcode_o, output, 6: instr_o[31:26], drives the decoder's instr_op_i.
- pc_plus4_o, output, 32: address of held instruction + 4.
- branch_taken_i, input, 1: the instruction being consumed is a taken beq/bne (Branch & zero/~zero, resolved downstream).
- branch_imm_i, input, 16: immediate field of that branch.
- instr_count_o, output, CNT_W: number of instructions consumed since reset.

Behaviour:
- Reset: rst_i asynchronous, active-high; single clock clk_i.
- While rst_i=1 and at release:
  - state=S_IDLE, pc_q=RESET_PC, instr_q=0.
  - instr_valid_o=0, imem_req_o=0, imem_addr_o=RESET_PC, instr_count_o=0.
- Asserting reset mid-fetch aborts the fetch. An imem_ack_i in any cycle with rst_i=1 is ignored.
- FSM states:
  - S_IDLE: outputs idle. Next cycle → S_REQ (exactly one idle cycle after reset release).
  - S_REQ: imem_req_o=1, imem_addr_o=pc_q, held stable until ack. On imem_ack_i=1: instr_q<=imem_rdata_i, → S_VALID. Otherwise stay. Zero-wait memory is allowed (ack in the first S_REQ cycle).
  - S_VALID: instr_valid_o=1, imem_req_o=0. instr_o/opcode_o/pc_plus4_o stay stable while instr_ready_i=0. On instr_ready_i=1 (handoff): update pc_q, instr_count_o+=1, → S_REQ.
- imem_ack_i outside S_REQ is ignored; no state or data change.
- Minimum throughput: one instruction per 2 cycles (REQ with immediate ack, then VALID with ready). Only one request outstanding ever.
- PC update at handoff:
  - not taken: pc_q <= pc_q + 4.
  - taken: pc_q <= pc_q + 4 + {{14{imm[15]}}, imm, 2'b00}.
  - All arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Negative offsets wrap likewise.
- branch_taken_i and branch_imm_i are sampled only on the handoff cycle and ignored otherwise.
- pc_plus4_o = pc_q + 4, combinational from pc_q, valid in all states.
- instr_count_o wraps to 0 after its maximum value.
- imem_addr_o[1:0] is always 0 when RESET_PC is aligned; an unaligned RESET_PC is a configuration error, not handled.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_ADDI=6'h08, OP_SLTIU=6'h0B, OP_ORI=6'h0D, OP_LUI=6'h0F.
  - fetch state enum: S_IDLE, S_REQ, S_VALID.
  - constant PC_STEP=32'd4.
- One sub-module: branch_target_adder. Sign-extend, shift-left-2, and add to pc+4. Combinational, 32-bit wrap. Reused later by the branch stage.

Test Plan:
- Reset then zero-wait memory, ready tied 1, rdata=32'h2008_0005:
  - First req at addr 0 one cycle after reset release.
  - instr_valid_o at the next edge with opcode_o=6'h08.
  - Subsequent addresses 4, 8, 12.
  - instr_count_o increments every 2 cycles.
- Memory ack delayed 3 cycles:
  - imem_req_o/imem_addr_o held stable for 3 cycles, instr_valid_o=0 throughout.
  - A spurious ack injected during S_VALID leaves instr_o unchanged.
- Backpressure: instr_ready_i=0 for 5 cycles in S_VALID → instr_o, pc_plus4_o and instr_count_o held; no new request issued.
- Taken branch consumed at pc=0x10:
  - imm=16'h0003 → next fetch addr 0x20.
  - imm=16'hFFFC → next fetch addr 0x04.
  - branch_taken_i=1 in a non-handoff cycle → no effect.
- Wrap: RESET_PC=32'hFFFF_FFFC, one handoff not taken → next fetch addr 0x0000_0000, pc_plus4_o=0 at the start.
- Reset asserted asynchronously mid-S_REQ with ack in the same cycle:
  - Outputs return to their reset values immediately, without waiting for an edge.
  - After release, fetch restarts at RESET_PC and the aborted data is never presented.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: opcode constants, the fetch-stage
// state encoding and the PC increment.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID
  } fetch_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target computation: pc+4 plus the sign-extended word offset,
// modulo 2^32. Shared with the branch stage.
module branch_target_adder (
  input  logic [31:0] pc_plus4,
  input  logic [15:0] imm,
  output logic [31:0] target
);

  logic [31:0] offset;

  always_comb begin
    offset = {{14{imm[15]}}, imm, 2'b00};
    target = pc_plus4 + offset;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding request to a variable-latency
// instruction memory, valid/ready handoff to the decoder, branch redirect.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic [5:0]       opcode_o,
  output logic [31:0]      pc_plus4_o,
  input  logic             branch_taken_i,
  input  logic [15:0]      branch_imm_i,
  output logic [CNT_W-1:0] instr_count_o
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, instr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      pc_plus4, branch_target;
  logic             load_instr, handoff;

  branch_target_adder u_bta (
    .pc_plus4 (pc_plus4),
    .imm      (branch_imm_i),
    .target   (branch_target)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Acks are only honoured in S_REQ; everywhere else they fall through unused.
  always_comb begin
    state_d       = state_q;
    load_instr    = 1'b0;
    handoff       = 1'b0;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          load_instr = 1'b1;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid_o = 1'b1;
        if (instr_ready_i) begin
          handoff = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      if (load_instr) instr_q <= imem_rdata_i;
      if (handoff) begin
        pc_q    <= branch_taken_i ? branch_target : pc_plus4;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pc_plus4      = pc_q + PC_STEP;
    imem_addr_o   = pc_q;
    instr_o       = instr_q;
    opcode_o      = instr_q[31:26];
    pc_plus4_o    = pc_plus4;
    instr_count_o = count_q;
  end

endmodule
